// File: rtl/mux4_pkg.sv
// Shared select type and select codes for the registered 4:1 multiplexer.
// Select word is {S2,S1}; every 2-bit code maps to one data input.
package mux4_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

endpackage

// File: rtl/mux4_comb.sv
// Purely combinational WIDTH-bit 4:1 selector driven by a sel_t code.
// Decoded as a ternary tree so an X on either select bit propagates to y.
module mux4_comb
  import mux4_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             sel,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;

  assign w_lo = sel[0] ? b : a;
  assign w_hi = sel[0] ? d : c;
  assign y    = sel[1] ? w_hi : w_lo;

endmodule

// File: rtl/mux4_reg.sv
// Registered 4:1 data multiplexer with synchronous active-high reset and load enable.
// Optional MUX4_PARITY_EN adds y_par, the registered XOR-reduction of the selected word.
module mux4_reg
  import mux4_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             S1,
  input  logic             S2,
`ifdef MUX4_PARITY_EN
  output logic             y_par,
`endif
  output logic [WIDTH-1:0] y
);

  sel_t             w_sel;
  logic [WIDTH-1:0] w_mux;
  logic [WIDTH-1:0] r_y;

  assign w_sel = {S2, S1};

  mux4_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (w_sel),
    .y   (w_mux)
  );

  // Reset wins over enable; with en low the register simply holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y <= '0;
    end else if (en) begin
      r_y <= w_mux;
    end
  end

  assign y = r_y;

`ifdef MUX4_PARITY_EN
  logic r_par;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (en) begin
      r_par <= ^w_mux;
    end
  end

  assign y_par = r_par;
`endif

endmodule

// File: tb/tb_mux4_reg.sv
// Self-checking bench for mux4_reg: WIDTH=2 and WIDTH=8 instances share controls,
// expected outputs come from a 1-cycle reference model through a scoreboard queue.
module tb_mux4_reg;
  import mux4_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       S1  = 1'b0;
  logic       S2  = 1'b0;
  logic [7:0] a8  = '0;
  logic [7:0] b8  = '0;
  logic [7:0] c8  = '0;
  logic [7:0] d8  = '0;
  logic [7:0] y8;
  logic [1:0] y2;
`ifdef MUX4_PARITY_EN
  logic       p8;
  logic       p2;
`endif

  always #5 clk = ~clk;

  mux4_reg #(.WIDTH(8)) dut8 (
    .clk (clk), .rst (rst), .en (en),
    .a (a8), .b (b8), .c (c8), .d (d8),
    .S1 (S1), .S2 (S2),
`ifdef MUX4_PARITY_EN
    .y_par (p8),
`endif
    .y (y8)
  );

  mux4_reg #(.WIDTH(2)) dut2 (
    .clk (clk), .rst (rst), .en (en),
    .a (a8[1:0]), .b (b8[1:0]), .c (c8[1:0]), .d (d8[1:0]),
    .S1 (S1), .S2 (S2),
`ifdef MUX4_PARITY_EN
    .y_par (p2),
`endif
    .y (y2)
  );

  typedef struct {
    logic [7:0] y8;
    logic [1:0] y2;
    logic       p8;
    logic       p2;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m8;
  logic [1:0] m2;
  int         n_run  = 0;
  int         n_fail = 0;
  bit         hit[4][2][2];

  function automatic logic [7:0] pick(sel_t s, logic [7:0] va, logic [7:0] vb,
                                      logic [7:0] vc, logic [7:0] vd);
    case (s)
      SEL_A:   return va;
      SEL_B:   return vb;
      SEL_C:   return vc;
      default: return vd;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input sel_t s,
                      input logic [7:0] va, input logic [7:0] vb,
                      input logic [7:0] vc, input logic [7:0] vd, input string tag);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; {S2, S1} = s;
    a8 = va; b8 = vb; c8 = vc; d8 = vd;
    hit[s][e][r] = 1'b1;
    if (r) begin
      m8 = '0;
      m2 = '0;
    end else if (e) begin
      m8 = pick(s, va, vb, vc, vd);
      m2 = m8[1:0];
    end
    x.y8 = m8;
    x.y2 = m2;
    x.p8 = ^m8;
    x.p2 = ^m2;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({tag, "/y8"}, y8, x.y8);
    chk({tag, "/y2"}, {6'b0, y2}, {6'b0, x.y2});
`ifdef MUX4_PARITY_EN
    chk({tag, "/p8"}, {7'b0, p8}, {7'b0, x.p8});
    chk({tag, "/p2"}, {7'b0, p2}, {7'b0, x.p2});
`endif
  endtask

  initial begin
    // reset state
    step(1'b1, 1'b1, SEL_D, 8'h5A, 8'hA5, 8'h3C, 8'hC3, "reset");
    chk("reset_const", y8, 8'h00);

    // select walk, each code held 5 cycles
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 5; k++) begin
        step(1'b0, 1'b1, sel_t'(s), 8'd0, 8'd1, 8'd2, 8'd3, "walk");
      end
      chk("walk_const", y8, 8'(s));
    end

    // reset mid-operation for 2 cycles with y=3, then resume
    step(1'b1, 1'b1, SEL_D, 8'd0, 8'd1, 8'd2, 8'd3, "rst_mid1");
    chk("rst_mid_const", y8, 8'h00);
    step(1'b1, 1'b1, SEL_D, 8'd0, 8'd1, 8'd2, 8'd3, "rst_mid2");
    step(1'b0, 1'b1, SEL_C, 8'd0, 8'd1, 8'd2, 8'd3, "rst_resume");
    chk("rst_resume_const", y8, 8'd2);

    // hold with en=0 while select and data move
    step(1'b0, 1'b0, SEL_D, 8'd0, 8'd1, 8'd2, 8'd1, "hold1");
    step(1'b0, 1'b0, SEL_D, 8'd0, 8'd1, 8'd2, 8'd1, "hold2");
    chk("hold_const", y8, 8'd2);
    step(1'b0, 1'b1, SEL_D, 8'd0, 8'd1, 8'd2, 8'd1, "hold_release");
    chk("release_const", y8, 8'd1);

    // simultaneous select and data change
    step(1'b0, 1'b1, SEL_A, 8'd0, 8'd0, 8'd0, 8'd0, "simul_pre");
    step(1'b0, 1'b1, SEL_B, 8'd0, 8'd3, 8'd0, 8'd0, "simul");
    chk("simul_const", y8, 8'd3);

    // parity-oriented values 0..3 through input a
    for (int v = 0; v < 4; v++) begin
      step(1'b0, 1'b1, SEL_A, 8'(v), 8'hFF, 8'hFF, 8'hFF, "par_seq");
    end

    // every sel/en/rst combination with random data
    for (int s = 0; s < 4; s++) begin
      for (int e = 0; e < 2; e++) begin
        for (int r = 0; r < 2; r++) begin
          step(1'(r), 1'(e), sel_t'(s), 8'($urandom), 8'($urandom),
               8'($urandom), 8'($urandom), "combo");
        end
      end
    end

    // random sweep; reset kept rare so loads dominate
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 9) == 0), 1'($urandom), sel_t'($urandom_range(0, 3)),
           8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), "rand");
    end

    for (int s = 0; s < 4; s++) begin
      for (int e = 0; e < 2; e++) begin
        for (int r = 0; r < 2; r++) begin
          if (!hit[s][e][r]) begin
            n_fail++;
            $display("FAIL coverage: sel=%0d en=%0d rst=%0d hit 0 required 1", s, e, r);
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
